// File: rtl/car_pkg.sv
// Shared encodings for the car motion arbiter.
//   dir field  (out_mode[3:2]) : DIR_STOP / DIR_FWD / DIR_BACK
//   rot field  (out_mode[1:0]) : ROT_HOLD / ROT_LEFT / ROT_RIGHT
//   car_state codes            : ST_MANUAL / ST_AUTO / ST_DANCE / ST_BRAKE
//   DANCE_TABLE                : eight {dir, rot} moves, index 0 is leftmost
package car_pkg;

  localparam logic [1:0] DIR_STOP  = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_BACK  = 2'b01;

  localparam logic [1:0] ROT_HOLD  = 2'b00;
  localparam logic [1:0] ROT_LEFT  = 2'b10;
  localparam logic [1:0] ROT_RIGHT = 2'b01;

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_AUTO   = 2'd1;
  localparam logic [1:0] ST_DANCE  = 2'd2;
  localparam logic [1:0] ST_BRAKE  = 2'd3;

  localparam logic [0:7][3:0] DANCE_TABLE = {
    DIR_FWD,  ROT_LEFT,
    DIR_FWD,  ROT_RIGHT,
    DIR_BACK, ROT_LEFT,
    DIR_BACK, ROT_RIGHT,
    DIR_STOP, ROT_LEFT,
    DIR_STOP, ROT_RIGHT,
    DIR_FWD,  ROT_HOLD,
    DIR_BACK, ROT_HOLD
  };

  // True when the request is the opposite running direction of what is applied.
  function automatic logic is_reversal(input logic [1:0] req, input logic [1:0] applied);
    return ((req == DIR_FWD) && (applied == DIR_BACK)) ||
           ((req == DIR_BACK) && (applied == DIR_FWD));
  endfunction

endpackage

// File: rtl/motor_deadtime.sv
// DC motor direction dead-time guard.
// Ports:
//   clk       system clock
//   rst_n     asynchronous reset, active-low
//   i_req_dir requested direction (DIR_* encoding)
//   o_dir     applied (registered) direction
// A reversal forces DEAD_CYCLES cycles of stop; stop<->run changes pass straight through.
module motor_deadtime
  import car_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 8
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req_dir,
  output logic [1:0] o_dir
);

  localparam int unsigned CW = $clog2(DEAD_CYCLES + 1);

  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

  logic          r_fsm;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= ST_RUN;
      r_cnt <= '0;
      r_dir <= DIR_STOP;
    end else if (r_fsm == ST_RUN) begin
      if (is_reversal(i_req_dir, r_dir)) begin
        r_fsm <= ST_DRAIN;
        r_cnt <= CW'(DEAD_CYCLES - 1);
        r_dir <= DIR_STOP;
      end else begin
        r_dir <= i_req_dir;
      end
    end else begin
      // Drain runs to completion whatever is requested meanwhile.
      if (r_cnt == '0) begin
        r_fsm <= ST_RUN;
        r_dir <= i_req_dir;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign o_dir = r_dir;

endmodule

// File: rtl/car_motion_arbiter.sv
// Car motion arbiter: selects brake / dance / auto / manual as motor source.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   forward/backward/left/right  manual button levels
//   car_break_signal         brake (highest priority)
//   auto_mode_signal         line-follow enable
//   dance_mode_signal        dance enable
//   left/right_line_signal   line sensors, 1 = line seen
//   beat_tick, step_tick     music beat pulse, stepper step pulse
//   out_mode                 {dir[1:0], rot[1:0]}, registered
//   car_state                selected source, registered
//   lost                     auto halted after the line was lost
module car_motion_arbiter
  import car_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 8,
  parameter int unsigned STEER_MAX   = 16,
  parameter int unsigned DANCE_BEATS = 4,
  parameter int unsigned LOST_CYCLES = 1024
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       forward,
  input  logic       backward,
  input  logic       left,
  input  logic       right,
  input  logic       car_break_signal,
  input  logic       auto_mode_signal,
  input  logic       dance_mode_signal,
  input  logic       left_line_signal,
  input  logic       right_line_signal,
  input  logic       beat_tick,
  input  logic       step_tick,
  output logic [3:0] out_mode,
  output logic [1:0] car_state,
  output logic       lost
);

  localparam int unsigned PW = $clog2(STEER_MAX + 1) + 1;
  localparam int unsigned BW = $clog2(DANCE_BEATS + 1);
  localparam int unsigned LW = $clog2(LOST_CYCLES + 1);
  localparam logic signed [PW-1:0] POS_MAX = PW'(STEER_MAX);
  localparam logic signed [PW-1:0] POS_MIN = -POS_MAX;

  logic [1:0]           w_sel;
  logic [1:0]           w_req_dir;
  logic [1:0]           w_req_rot;
  logic [1:0]           w_rot;
  logic [1:0]           w_dir;

  logic [1:0]           r_state;
  logic [1:0]           r_rot;
  logic                 r_lost;
  logic [LW-1:0]        r_lost_cnt;
  logic signed [PW-1:0] r_steer_pos;
  logic [2:0]           r_dance_idx;
  logic [BW-1:0]        r_beat_cnt;

  always_comb begin
    if (car_break_signal)       w_sel = ST_BRAKE;
    else if (dance_mode_signal) w_sel = ST_DANCE;
    else if (auto_mode_signal)  w_sel = ST_AUTO;
    else                        w_sel = ST_MANUAL;
  end

  always_comb begin
    w_req_dir = DIR_STOP;
    w_req_rot = ROT_HOLD;
    case (w_sel)
      ST_MANUAL: begin
        if (forward && !backward)      w_req_dir = DIR_FWD;
        else if (backward && !forward) w_req_dir = DIR_BACK;
        if (left && !right)            w_req_rot = ROT_LEFT;
        else if (right && !left)       w_req_rot = ROT_RIGHT;
      end
      ST_AUTO: begin
        if (!r_lost) begin
          if (left_line_signal || right_line_signal) w_req_dir = DIR_FWD;
          if (left_line_signal && !right_line_signal)      w_req_rot = ROT_LEFT;
          else if (right_line_signal && !left_line_signal) w_req_rot = ROT_RIGHT;
        end
      end
      ST_DANCE: {w_req_dir, w_req_rot} = DANCE_TABLE[r_dance_idx];
      default: ;
    endcase
  end

  // Refuse to drive the stepper further once the wheel sits at a limit.
  always_comb begin
    w_rot = w_req_rot;
    if ((w_req_rot == ROT_LEFT  && r_steer_pos == POS_MAX) ||
        (w_req_rot == ROT_RIGHT && r_steer_pos == POS_MIN))
      w_rot = ROT_HOLD;
  end

  motor_deadtime #(
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_deadtime (
    .clk       (clk),
    .rst_n     (rst),
    .i_req_dir (w_req_dir),
    .o_dir     (w_dir)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_MANUAL;
      r_rot   <= ROT_HOLD;
    end else begin
      r_state <= w_sel;
      r_rot   <= w_rot;
    end
  end

  // Position follows the rotation actually issued to the stepper.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_steer_pos <= '0;
    end else if (step_tick) begin
      if (r_rot == ROT_LEFT && r_steer_pos < POS_MAX)
        r_steer_pos <= r_steer_pos + PW'(1);
      else if (r_rot == ROT_RIGHT && r_steer_pos > POS_MIN)
        r_steer_pos <= r_steer_pos - PW'(1);
    end
  end

  // Held at zero outside DANCE, so every entry starts from move 0, beat 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dance_idx <= '0;
      r_beat_cnt  <= '0;
    end else if (w_sel != ST_DANCE) begin
      r_dance_idx <= '0;
      r_beat_cnt  <= '0;
    end else if (beat_tick) begin
      if (r_beat_cnt == BW'(DANCE_BEATS - 1)) begin
        r_beat_cnt  <= '0;
        r_dance_idx <= r_dance_idx + 3'd1;
      end else begin
        r_beat_cnt <= r_beat_cnt + BW'(1);
      end
    end
  end

  // Lost latches until AUTO is no longer the selected source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lost     <= 1'b0;
      r_lost_cnt <= '0;
    end else if (w_sel != ST_AUTO) begin
      r_lost     <= 1'b0;
      r_lost_cnt <= '0;
    end else if (!r_lost) begin
      if (left_line_signal || right_line_signal) begin
        r_lost_cnt <= '0;
      end else if (r_lost_cnt == LW'(LOST_CYCLES - 1)) begin
        r_lost     <= 1'b1;
        r_lost_cnt <= '0;
      end else begin
        r_lost_cnt <= r_lost_cnt + LW'(1);
      end
    end
  end

  assign out_mode  = {w_dir, r_rot};
  assign car_state = r_state;
  assign lost      = r_lost;

endmodule

// File: tb/tb_car_motion_arbiter.sv
module tb_car_motion_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic forward = 1'b0, backward = 1'b0, left = 1'b0, right = 1'b0;
  logic car_break_signal = 1'b0, auto_mode_signal = 1'b0, dance_mode_signal = 1'b0;
  logic left_line_signal = 1'b0, right_line_signal = 1'b0;
  logic beat_tick = 1'b0, step_tick = 1'b0;
  logic [3:0] out_mode;
  logic [1:0] car_state;
  logic       lost;

  car_motion_arbiter #(
    .DEAD_CYCLES (4),
    .STEER_MAX   (16),
    .DANCE_BEATS (4),
    .LOST_CYCLES (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .forward           (forward),
    .backward          (backward),
    .left              (left),
    .right             (right),
    .car_break_signal  (car_break_signal),
    .auto_mode_signal  (auto_mode_signal),
    .dance_mode_signal (dance_mode_signal),
    .left_line_signal  (left_line_signal),
    .right_line_signal (right_line_signal),
    .beat_tick         (beat_tick),
    .step_tick         (step_tick),
    .out_mode          (out_mode),
    .car_state         (car_state),
    .lost              (lost)
  );

  always #5 clk = ~clk;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: expected {out_mode, car_state, lost} keyed by sample cycle.
  int         q_cyc[$];
  logic [6:0] q_exp[$];
  string      q_name[$];

  int         m_tc;
  logic [6:0] m_exp;
  logic [6:0] m_got;
  string      m_name;

  task automatic expect_out(input int n, input logic [3:0] m, input logic [1:0] s,
                            input logic l, input string nm);
    q_cyc.push_back(cyc + n);
    q_exp.push_back({m, s, l});
    q_name.push_back(nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    forward = 1'b0; backward = 1'b0; left = 1'b0; right = 1'b0;
    car_break_signal = 1'b0; auto_mode_signal = 1'b0; dance_mode_signal = 1'b0;
    left_line_signal = 1'b0; right_line_signal = 1'b0;
    beat_tick = 1'b0; step_tick = 1'b0;
    expect_out(1, 4'b0000, 2'd0, 1'b0, "reset");
    tick(1);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic beat_pulse(input logic [3:0] m1, input logic [3:0] m2, input string nm);
    expect_out(1, m1, 2'd2, 1'b0, nm);
    expect_out(2, m2, 2'd2, 1'b0, nm);
    beat_tick = 1'b1;
    tick(1);
    beat_tick = 1'b0;
    tick(1);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
        m_tc   = q_cyc.pop_front();
        m_exp  = q_exp.pop_front();
        m_name = q_name.pop_front();
        m_got  = {out_mode, car_state, lost};
        n_checks++;
        if (m_tc == cyc && m_got === m_exp)
          n_pass++;
        else
          $display("FAIL %s cyc=%0d: got mode=%b state=%0d lost=%b, expected mode=%b state=%0d lost=%b (due cyc %0d)",
                   m_name, cyc, m_got[6:3], m_got[2:1], m_got[0],
                   m_exp[6:3], m_exp[2:1], m_exp[0], m_tc);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    do_reset();

    // Manual forward, then a clean reversal with dead-time.
    forward = 1'b1;
    expect_out(1, 4'b1000, 2'd0, 1'b0, "manual_fwd");
    tick(1);
    forward = 1'b0; backward = 1'b1;
    for (int i = 1; i <= 4; i++) expect_out(i, 4'b0000, 2'd0, 1'b0, "rev_deadtime");
    expect_out(5, 4'b0100, 2'd0, 1'b0, "rev_back");
    tick(5);

    // Back->fwd reversal; a one-cycle brake mid-drain must not end the drain early.
    backward = 1'b0; forward = 1'b1;
    expect_out(1, 4'b0000, 2'd0, 1'b0, "rev2_drain");
    expect_out(2, 4'b0000, 2'd0, 1'b0, "rev2_drain");
    tick(2);
    car_break_signal = 1'b1;
    expect_out(1, 4'b0000, 2'd3, 1'b0, "brake_in_drain");
    tick(1);
    car_break_signal = 1'b0;
    expect_out(1, 4'b0000, 2'd0, 1'b0, "drain_no_early_exit");
    expect_out(2, 4'b1000, 2'd0, 1'b0, "rev2_fwd");
    tick(2);

    // Brake over forward + auto, then release into auto.
    auto_mode_signal = 1'b1; car_break_signal = 1'b1;
    expect_out(1, 4'b0000, 2'd3, 1'b0, "brake_over_auto");
    expect_out(2, 4'b0000, 2'd3, 1'b0, "brake_hold");
    tick(2);
    left_line_signal = 1'b1; right_line_signal = 1'b1; car_break_signal = 1'b0;
    expect_out(1, 4'b1000, 2'd1, 1'b0, "brake_release_auto");
    tick(1);
    auto_mode_signal = 1'b0;
    expect_out(1, 4'b1000, 2'd0, 1'b0, "auto_to_manual");
    tick(1);
    forward = 1'b0;
    expect_out(1, 4'b0000, 2'd0, 1'b0, "manual_stop");
    tick(1);

    // Dance: moves 0,1, dead-time into move 2, then wrap 7->0.
    do_reset();
    dance_mode_signal = 1'b1;
    expect_out(1, 4'b1010, 2'd2, 1'b0, "dance_move0");
    tick(1);
    for (int i = 0; i < 3; i++) beat_pulse(4'b1010, 4'b1010, "dance_move0_hold");
    beat_pulse(4'b1010, 4'b1001, "dance_move1");
    for (int i = 0; i < 3; i++) beat_pulse(4'b1001, 4'b1001, "dance_move1_hold");
    beat_pulse(4'b1001, 4'b0010, "dance_move2_drain");
    for (int i = 1; i <= 3; i++) expect_out(i, 4'b0010, 2'd2, 1'b0, "dance_move2_drain");
    expect_out(4, 4'b0110, 2'd2, 1'b0, "dance_move2");
    tick(4);
    for (int i = 0; i < 20; i++) begin
      beat_tick = 1'b1; tick(1);
      beat_tick = 1'b0; tick(1);
    end
    tick(9);
    expect_out(1, 4'b0100, 2'd2, 1'b0, "dance_move7");
    tick(1);
    for (int i = 0; i < 4; i++) begin
      beat_tick = 1'b1; tick(1);
      beat_tick = 1'b0; tick(1);
    end
    tick(9);
    expect_out(1, 4'b1010, 2'd2, 1'b0, "dance_wrap_move0");
    tick(1);
    dance_mode_signal = 1'b0;
    expect_out(1, 4'b0000, 2'd0, 1'b0, "dance_exit");
    tick(1);

    // Auto: line-follow, lost counter clear, lost latch.
    do_reset();
    auto_mode_signal = 1'b1; left_line_signal = 1'b1;
    expect_out(1, 4'b1010, 2'd1, 1'b0, "auto_left");
    tick(1);
    left_line_signal = 1'b0;
    for (int i = 1; i <= 10; i++) expect_out(i, 4'b0000, 2'd1, 1'b0, "auto_no_line");
    tick(10);
    right_line_signal = 1'b1;
    expect_out(1, 4'b1001, 2'd1, 1'b0, "auto_right_reseen");
    tick(1);
    right_line_signal = 1'b0;
    expect_out(1, 4'b0000, 2'd1, 1'b0, "auto_lost_count");
    expect_out(15, 4'b0000, 2'd1, 1'b0, "auto_lost_minus1");
    expect_out(16, 4'b0000, 2'd1, 1'b1, "auto_lost_set");
    tick(16);
    left_line_signal = 1'b1;
    for (int i = 1; i <= 3; i++) expect_out(i, 4'b0000, 2'd1, 1'b1, "auto_lost_sticky");
    tick(3);
    auto_mode_signal = 1'b0;
    expect_out(1, 4'b0000, 2'd0, 1'b0, "auto_leave_clears_lost");
    tick(1);
    auto_mode_signal = 1'b1;
    expect_out(1, 4'b1010, 2'd1, 1'b0, "auto_reenter");
    tick(1);

    // Steering saturation at +16 with 20 step ticks.
    do_reset();
    left = 1'b1;
    expect_out(1, 4'b0010, 2'd0, 1'b0, "steer_left");
    tick(1);
    for (int i = 1; i <= 20; i++) begin
      expect_out(1, (i <= 16) ? 4'b0010 : 4'b0000, 2'd0, 1'b0, "steer_step");
      expect_out(2, (i <= 15) ? 4'b0010 : 4'b0000, 2'd0, 1'b0, "steer_step");
      step_tick = 1'b1; tick(1);
      step_tick = 1'b0; tick(1);
    end
    left = 1'b0; right = 1'b1;
    expect_out(1, 4'b0001, 2'd0, 1'b0, "steer_right_at_limit");
    tick(1);
    expect_out(1, 4'b0001, 2'd0, 1'b0, "steer_right_step");
    expect_out(2, 4'b0001, 2'd0, 1'b0, "steer_right_step");
    step_tick = 1'b1; tick(1);
    step_tick = 1'b0; tick(1);
    right = 1'b0; left = 1'b1;
    expect_out(1, 4'b0010, 2'd0, 1'b0, "steer_left_off_limit");
    tick(1);
    left = 1'b0;
    expect_out(1, 4'b0000, 2'd0, 1'b0, "steer_release");
    tick(1);

    tick(2);
    if (q_cyc.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations never sampled, required 0", q_cyc.size());
      n_checks += q_cyc.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
